ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port access controller in front of the 2^16 x 32 data RAM's load/store port. It arbitrates round-robin between the CPU load/store unit (port 0) and the program loader/debug port (port 1), then sequences each granted transaction onto the RAM's `read_write`/`address`/`data_in`/`data_out` pins. Write sequencing guarantees that exactly one `data_in` transition occurs while `read_write` is low, because the RAM commits writes on `data_in` events. The instruction-fetch port of the RAM is not touched by this block.

## Interface
- `DATA_SIZE`, 32, word width.
- `ADDRESS_SIZE`, 16, word-address width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  level request from requester 0 / 1; held until the matching ack.
- `we0` / `we1`  in  1  1 = store (STR), 0 = load (LDR); stable while req high.
- `addr0` / `addr1`  in  ADDRESS_SIZE  word address; stable while req high.
- `wdata0` / `wdata1`  in  DATA_SIZE  store data; stable while req high.
- `ack0` / `ack1`  out  1  one-cycle completion pulse to requester 0 / 1.
- `rdata`  out  DATA_SIZE  load result; valid in the ack cycle and held until the next load completes.
- `busy`  out  1  high in every state except IDLE.
- `ram_read_write`  out  1  to RAM `read_write`; 1 = read/idle.
- `ram_address`  out  ADDRESS_SIZE  to RAM `address`.
- `ram_data_in`  out  DATA_SIZE  to RAM `data_in`.
- `ram_data_out`  in  DATA_SIZE  from RAM `data_out`.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - `ram_read_write`=1
  - `ram_address`=0, `ram_data_in`=0
  - `rdata`=0
  - `ack0`=`ack1`=0, `busy`=0
  - `last_grant`=1, so port 0 wins the first contest.
- FSM states: IDLE, RD, WR_PREP, WR_ARM, WR_STROBE, ACK.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant `!last_grant`.
  - Latch `gnt`, `we`, `addr`, `wdata` of the winner and update `last_grant`.
  - Go to RD if `we`=0, else WR_PREP.
- RD: drive `ram_address`=addr with `ram_read_write`=1. On exit, capture `ram_data_out` into `rdata`. Go to ACK.
- WR_PREP: drive `ram_read_write`=1, `ram_address`=addr, `ram_data_in`=~wdata. No write occurs because rw=1.
- WR_ARM: `ram_read_write`=0, `ram_data_in` held at ~wdata, so there is no data event.
- WR_STROBE: `ram_data_in`=wdata, which is a guaranteed transition, and the RAM commits the write. `ram_read_write` stays 0.
- ACK:
  - Pulse `ack[gnt]`.
  - Set `ram_read_write`=1. `ram_address` and `ram_data_in` hold.
  - Go to IDLE.
- Requesters must deassert req on the edge ending their ack cycle. A req still high in IDLE is a new transaction.
- `ram_read_write` is never 0 in IDLE, RD, WR_PREP or ACK.
- A reset asserted mid-transaction aborts it immediately:
  - no ack is issued;
  - rw returns to 1 asynchronously;
  - a write aborted in WR_ARM leaves memory unchanged;
  - a write aborted after WR_STROBE is committed.

## Timing
- Let edge T be the IDLE edge that samples a request.
- Load: RD in cycle T+1, ACK in T+2. Ack rises 2 cycles after sampling; `rdata` is valid in the same cycle.
- Store: WR_PREP T+1, WR_ARM T+2, WR_STROBE T+3, ACK T+4. Memory is updated during T+3.
- Throughput with back-to-back requests:
  - one load per 3 cycles;
  - one store per 5 cycles (IDLE is included each time).
- Contention: with both reqs held continuously, grants alternate 0,1,0,1. Neither port waits more than one foreign transaction.
- Fetch reads are concurrent and unaffected. Same-address fetch during WR_STROBE returns the new value from T+3.

## Structure
- Shared package `mem_pkg`:
  - `DATA_SIZE`, `ADDRESS_SIZE`;
  - the state enum (IDLE, RD, WR_PREP, WR_ARM, WR_STROBE, ACK);
  - a `mem_req_t` struct {we, addr, wdata}.
- One sub-module, `rr_arb2`: 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, enable.
  - Outputs: gnt index, valid.
- The FSM and datapath registers stay in `ram_arbiter`.

## Test plan
- Reset, then req0 load addr 0x0010 (mem=0xDEADBEEF) -> `ack0` at T+2 with `rdata`=0xDEADBEEF; `ack1`=0; rw never low.
- req1 store addr 0x0020 data 0x12345678, then req1 load 0x0020 -> `ack1` at T+4; load returns 0x12345678. During the store, rw=0 only in WR_ARM/WR_STROBE and `ram_data_in` changes exactly once while rw=0.
- Store the same value 0x0 twice to 0x0030 after preloading 0xFFFFFFFF -> memory reads 0x0; the second store still produces a data_in event.
- req0 and req1 both held with 4 loads each -> acks ordered 0,1,0,1,0,1,0,1; first grant goes to port 0 after reset.
- Reset asserted in WR_ARM of a store of 0xAAAA5555 to 0x0040 (old 0x0) -> no ack; rw=1 immediately; 0x0040 still reads 0x0; the next request is served normally.
- Store to 0x00FF while checking fetch from 0xFF -> `fetch_out` shows the new value from the WR_STROBE cycle onward.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM access controller.
//   DATA_SIZE / ADDRESS_SIZE : word width and word-address width of the RAM
//   state_t                  : sequencing states of ram_arbiter
//   mem_req_t                : a latched request {we, addr, wdata}
package mem_pkg;
  localparam int DATA_SIZE    = 32;
  localparam int ADDRESS_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE, RD, WR_PREP, WR_ARM, WR_STROBE, ACK
  } state_t;

  typedef struct packed {
    logic                    we;
    logic [ADDRESS_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0]    wdata;
  } mem_req_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM load/store pins.
//   req*/we*/addr*/wdata*  : requester side, level request held until ack
//   ack*/rdata/busy        : completion pulses, load data, activity flag
//   ram_*                  : RAM read_write/address/data_in/data_out pins
// Modports: slave = the arbiter, master = requesters + RAM.
interface ram_arbiter_if;
  import mem_pkg::*;

  logic                    req0, req1;
  logic                    we0, we1;
  logic [ADDRESS_SIZE-1:0] addr0, addr1;
  logic [DATA_SIZE-1:0]    wdata0, wdata1;
  logic                    ack0, ack1;
  logic [DATA_SIZE-1:0]    rdata;
  logic                    busy;
  logic                    ram_read_write;
  logic [ADDRESS_SIZE-1:0] ram_address;
  logic [DATA_SIZE-1:0]    ram_data_in;
  logic [DATA_SIZE-1:0]    ram_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    output ack0, ack1, rdata, busy, ram_read_write, ram_address, ram_data_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    input  ack0, ack1, rdata, busy, ram_read_write, ram_address, ram_data_in
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
//   req[1:0]   : pending requests
//   last_grant : port granted most recently; the other port wins a tie
//   enable     : only pick when the caller can accept a grant
//   gnt        : winning port index
//   valid      : a grant is being offered this cycle
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic       gnt,
  output logic       valid
);
  always_comb begin
    valid = enable & (|req);
    gnt   = (req == 2'b11) ? ~last_grant : req[1];
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin access controller in front of the data RAM's load/store port.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : ram_arbiter_if.slave (requester handshake + RAM pins)
// The RAM commits a write on any data_in event while read_write is low, so a
// store pre-loads data_in with ~wdata while rw is still high, drops rw with
// data_in unchanged, then flips data_in to wdata: exactly one event with rw=0.
// All outputs are registered; the comb block computes their next values.
module ram_arbiter
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);
  state_t                  state, state_nx;
  mem_req_t                cur_q, cur_nx, win;
  logic                    gnt_q, gnt_nx;
  logic                    last_grant_q, last_nx;
  logic                    pick_gnt, pick_vld;

  logic                    rw_q, rw_nx;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_nx;
  logic [DATA_SIZE-1:0]    din_q, din_nx;
  logic [DATA_SIZE-1:0]    rdata_q, rdata_nx;
  logic [1:0]              ack_q, ack_nx;
  logic                    busy_q, busy_nx;

  rr_arb2 u_arb (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_grant_q),
    .enable     (state == IDLE),
    .gnt        (pick_gnt),
    .valid      (pick_vld)
  );

  always_comb begin
    win = pick_gnt ? mem_req_t'{bus.we1, bus.addr1, bus.wdata1}
                   : mem_req_t'{bus.we0, bus.addr0, bus.wdata0};
  end

  // Next-state and next-output logic; every rw_nx etc. is the value the pin
  // will carry in the state being entered.
  always_comb begin
    state_nx = state;
    cur_nx   = cur_q;
    gnt_nx   = gnt_q;
    last_nx  = last_grant_q;
    rw_nx    = 1'b1;
    addr_nx  = addr_q;
    din_nx   = din_q;
    rdata_nx = rdata_q;
    ack_nx   = 2'b00;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          cur_nx  = win;
          gnt_nx  = pick_gnt;
          last_nx = pick_gnt;
          addr_nx = win.addr;
          if (win.we) begin
            din_nx   = ~win.wdata;   // arm data_in opposite to the final value
            state_nx = WR_PREP;
          end else begin
            state_nx = RD;
          end
        end
      end
      RD: begin
        addr_nx = cur_q.addr;
        if (!cur_q.we) rdata_nx = bus.ram_data_out;
        ack_nx[gnt_q] = 1'b1;
        state_nx = ACK;
      end
      WR_PREP: begin
        addr_nx  = cur_q.addr;
        rw_nx    = 1'b0;             // drop rw with data_in held: no event
        state_nx = WR_ARM;
      end
      WR_ARM: begin
        addr_nx  = cur_q.addr;
        rw_nx    = 1'b0;
        din_nx   = cur_q.wdata;      // the single committing transition
        state_nx = WR_STROBE;
      end
      WR_STROBE: begin
        addr_nx = cur_q.addr;
        ack_nx[gnt_q] = 1'b1;
        state_nx = ACK;
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;          // port 0 wins the first contest
      rw_q         <= 1'b1;
      addr_q       <= '0;
      din_q        <= '0;
      rdata_q      <= '0;
      ack_q        <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      cur_q        <= cur_nx;
      gnt_q        <= gnt_nx;
      last_grant_q <= last_nx;
      rw_q         <= rw_nx;
      addr_q       <= addr_nx;
      din_q        <= din_nx;
      rdata_q      <= rdata_nx;
      ack_q        <= ack_nx;
      busy_q       <= busy_nx;
    end
  end

  assign bus.ram_read_write = rw_q;
  assign bus.ram_address    = addr_q;
  assign bus.ram_data_in    = din_q;
  assign bus.rdata          = rdata_q;
  assign bus.ack0           = ack_q[0];
  assign bus.ack1           = ack_q[1];
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM that commits on data_in events
// while read_write is low, plus a transaction-level shadow memory.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if bus();
  ram_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));

  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [int];
  int errors = 0;
  int checks = 0;
  int din_ev = 0;

  assign bus.ram_data_out = mem[bus.ram_address];

  // RAM write behaviour: a data_in event with read_write low commits.
  always @(bus.ram_data_in) begin
    if (!reset && bus.ram_read_write === 1'b0) begin
      mem[bus.ram_address] = bus.ram_data_in;
      din_ev++;
    end
  end

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic preload(input int a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic drop_reqs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  // Drives one request from a negedge and waits for its ack (bounded).
  // lat = negedges from drive to ack cycle, -1 if it never came.
  task automatic run_txn(input bit port, input bit we, input logic [15:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output int rw_low, output int ev, output bit other_ack);
    lat = -1; rd = 'x; rw_low = 0; other_ack = 0; din_ev = 0;
    if (port) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    else      begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.ram_read_write === 1'b0) rw_low++;
      if ((port ? bus.ack0 : bus.ack1) !== 1'b0) other_ack = 1;
      if ((port ? bus.ack1 : bus.ack0) === 1'b1) begin
        lat = c; rd = bus.rdata; break;
      end
    end
    if (port) bus.req1 = 0; else bus.req0 = 0;
    ev = din_ev;
  endtask

  task automatic apply_reset();
    drop_reqs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.ram_read_write !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b want 1", bus.ram_read_write); end
    checks++; if (bus.ram_address !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.ram_address); end
    checks++; if (bus.ram_data_in !== 32'h0) begin errors++; $display("FAIL reset_din: got %h want 0", bus.ram_data_in); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    checks++; if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin errors++; $display("FAIL reset_ack_busy: got %b want 000", {bus.ack0, bus.ack1, bus.busy}); end
  endtask

  task automatic test_load();
    int lat, rwl, ev; logic [31:0] rd; bit oa;
    preload(16'h0010, 32'hDEADBEEF);
    run_txn(0, 0, 16'h0010, 32'h0, lat, rd, rwl, ev, oa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
    checks++; if (rwl !== 0) begin errors++; $display("FAIL load_rw_low: got %0d want 0", rwl); end
    checks++; if (oa !== 1'b0) begin errors++; $display("FAIL load_ack1: got %b want 0", oa); end
  endtask

  task automatic test_store_load();
    int lat, rwl, ev; logic [31:0] rd; bit oa;
    @(negedge clk);
    run_txn(1, 1, 16'h0020, 32'h12345678, lat, rd, rwl, ev, oa);
    ref_mem[16'h0020] = 32'h12345678;
    checks++; if (lat !== 4) begin errors++; $display("FAIL store_latency: got %0d want 4", lat); end
    checks++; if (rwl !== 2) begin errors++; $display("FAIL store_rw_low_cycles: got %0d want 2", rwl); end
    checks++; if (ev !== 1) begin errors++; $display("FAIL store_din_events: got %0d want 1", ev); end
    checks++; if (oa !== 1'b0) begin errors++; $display("FAIL store_ack0: got %b want 0", oa); end
    @(negedge clk);
    run_txn(1, 0, 16'h0020, 32'h0, lat, rd, rwl, ev, oa);
    checks++; if (rd !== ref_rd(16'h0020)) begin errors++; $display("FAIL store_readback: got %h want %h", rd, ref_rd(16'h0020)); end
  endtask

  task automatic test_same_value();
    int lat, rwl, ev; logic [31:0] rd; bit oa;
    preload(16'h0030, 32'hFFFFFFFF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      run_txn(0, 1, 16'h0030, 32'h0, lat, rd, rwl, ev, oa);
      checks++; if (ev !== 1) begin errors++; $display("FAIL same_value_events[%0d]: got %0d want 1", k, ev); end
      checks++; if (mem[16'h0030] !== 32'h0) begin errors++; $display("FAIL same_value_mem[%0d]: got %h want 0", k, mem[16'h0030]); end
    end
    ref_mem[16'h0030] = 32'h0;
  endtask

  task automatic test_contention();
    int idx0, idx1, n;
    int order [$];
    apply_reset();
    for (int i = 0; i < 8; i++) preload(16'h0050 + i, $urandom);
    idx0 = 0; idx1 = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0050;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0054;
    for (int c = 0; c < 200 && (idx0 < 4 || idx1 < 4); c++) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1) begin
        order.push_back(0);
        checks++; if (bus.rdata !== ref_rd(16'h0050 + idx0)) begin errors++; $display("FAIL contention_rdata0: got %h want %h", bus.rdata, ref_rd(16'h0050 + idx0)); end
        idx0++;
        if (idx0 < 4) bus.addr0 = 16'h0050 + 16'(idx0); else bus.req0 = 0;
      end
      if (bus.ack1 === 1'b1) begin
        order.push_back(1);
        checks++; if (bus.rdata !== ref_rd(16'h0054 + idx1)) begin errors++; $display("FAIL contention_rdata1: got %h want %h", bus.rdata, ref_rd(16'h0054 + idx1)); end
        idx1++;
        if (idx1 < 4) bus.addr1 = 16'h0054 + 16'(idx1); else bus.req1 = 0;
      end
    end
    drop_reqs();
    n = order.size();
    checks++; if (n !== 8) begin errors++; $display("FAIL contention_count: got %0d want 8", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (order[i] !== (i % 2)) begin errors++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
    end
  endtask

  task automatic test_abort();
    int lat, rwl, ev; logic [31:0] rd; bit oa;
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0040; bus.wdata0 = 32'hAAAA5555;
    repeat (2) @(negedge clk);      // now in WR_ARM
    checks++; if (bus.ram_read_write !== 1'b0) begin errors++; $display("FAIL abort_in_arm_rw: got %b want 0", bus.ram_read_write); end
    reset = 1; bus.req0 = 0;
    #1;
    checks++; if (bus.ram_read_write !== 1'b1) begin errors++; $display("FAIL abort_rw_async: got %b want 1", bus.ram_read_write); end
    checks++; if ({bus.ack0, bus.ack1} !== 2'b00) begin errors++; $display("FAIL abort_ack: got %b want 00", {bus.ack0, bus.ack1}); end
    @(negedge clk);
    reset = 0;
    checks++; if (mem[16'h0040] !== ref_rd(16'h0040)) begin errors++; $display("FAIL abort_mem: got %h want %h", mem[16'h0040], ref_rd(16'h0040)); end
    run_txn(0, 0, 16'h0040, 32'h0, lat, rd, rwl, ev, oa);
    checks++; if (lat !== 2 || rd !== ref_rd(16'h0040)) begin errors++; $display("FAIL abort_next_load: got lat %0d data %h want lat 2 data %h", lat, rd, ref_rd(16'h0040)); end
  endtask

  task automatic test_fetch();
    logic [31:0] nv, old, exp;
    nv = $urandom | 32'h1;
    old = ref_rd(16'h00FF);
    @(negedge clk);
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h00FF; bus.wdata1 = nv;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp = (c >= 3) ? nv : old;
      checks++; if (mem[16'h00FF] !== exp) begin errors++; $display("FAIL fetch_cycle%0d: got %h want %h", c, mem[16'h00FF], exp); end
    end
    checks++; if (bus.ack1 !== 1'b1) begin errors++; $display("FAIL fetch_store_ack: got %b want 1", bus.ack1); end
    bus.req1 = 0;
    ref_mem[16'h00FF] = nv;
  endtask

  task automatic test_back_to_back();
    int lat, rwl, ev; logic [31:0] rd; bit oa;
    int exp_lat [4] = '{2, 3, 5, 5};
    bit     kind [4] = '{0, 0, 1, 1};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      run_txn(0, kind[k], 16'h0060 + 16'(k), 32'hC0DE0000 + k, lat, rd, rwl, ev, oa);
      if (kind[k]) ref_mem[16'h0060 + k] = 32'hC0DE0000 + k;
      checks++; if (lat !== exp_lat[k]) begin errors++; $display("FAIL back_to_back_lat[%0d]: got %0d want %0d", k, lat, exp_lat[k]); end
    end
  endtask

  task automatic test_random();
    int lat, rwl, ev; logic [31:0] rd, d; bit oa, port, we; logic [15:0] a;
    for (int k = 0; k < 24; k++) begin
      port = 1'($urandom); we = 1'($urandom);
      a = 16'h0100 + 16'($urandom_range(0, 7)); d = $urandom;
      @(negedge clk);
      run_txn(port, we, a, d, lat, rd, rwl, ev, oa);
      checks++; if (lat !== (we ? 4 : 2) || oa !== 1'b0) begin errors++; $display("FAIL rand_handshake[%0d]: got lat %0d other_ack %b want lat %0d", k, lat, oa, we ? 4 : 2); end
      if (we) begin
        ref_mem[a] = d;
        checks++; if (mem[a] !== d || ev !== 1 || rwl !== 2) begin errors++; $display("FAIL rand_store[%0d]: got mem %h ev %0d rwlow %0d want %h 1 2", k, mem[a], ev, rwl, d); end
      end else begin
        checks++; if (rd !== ref_rd(a) || rwl !== 0) begin errors++; $display("FAIL rand_load[%0d]: got %h rwlow %0d want %h 0", k, rd, rwl, ref_rd(a)); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    drop_reqs();
    test_reset();
    test_load();
    test_store_load();
    test_same_value();
    test_contention();
    test_abort();
    test_fetch();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
